// File: rtl/alu_result_bcd_display_if.sv
// Bus between the ALU result register and the BCD display stage.
// The master supplies the result and the start request; the slave returns status, digits and display pins.
interface alu_result_bcd_display_if;
  logic [7:0] result_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [2:0] digit_sel;
  logic [6:0] seg;

  modport master (
    output result_in, start,
    input  busy, done, hundreds, tens, ones, digit_sel, seg
  );

  modport slave (
    input  result_in, start,
    output busy, done, hundreds, tens, ones, digit_sel, seg
  );
endinterface

// File: rtl/alu_result_bcd_display.sv
// Converts the 8-bit ALU result to BCD with a sequential double-dabble (one shift per clock)
// and drives a time-multiplexed 3-digit 7-segment display with optional leading-zero blanking.
module alu_result_bcd_display #(
  parameter int SCAN_DIV = 10,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  alu_result_bcd_display_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state;
  logic [7:0]          bin_sr;
  logic [11:0]         bcd;
  logic [11:0]         bcd_adj;
  logic [2:0]          shift_cnt;
  logic                busy_q;
  logic                done_q;
  logic [3:0]          hundreds_q;
  logic [3:0]          tens_q;
  logic [3:0]          ones_q;
  logic [SCAN_DIV-1:0] prescale;
  logic [2:0]          sel_q;
  logic [3:0]          cur_digit;
  logic [6:0]          seg_c;

  function automatic logic [11:0] add3_nibbles(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    for (int i = 0; i < 3; i++) begin
      if (d[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign bcd_adj = add3_nibbles(bcd);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hundreds_q <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr    <= bus.result_in;
            bcd       <= '0;
            shift_cnt <= '0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
          shift_cnt     <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) state <= LATCH;
        end
        LATCH: begin
          // Digits change only here, so the display never shows a partial conversion.
          hundreds_q <= bcd[11:8];
          tens_q     <= bcd[7:4];
          ones_q     <= bcd[3:0];
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan runs independently of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      sel_q    <= 3'b001;
    end else begin
      prescale <= prescale + 1'b1;
      if (&prescale) sel_q <= {sel_q[1:0], sel_q[2]};
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cur_digit = ones_q;
    seg_c     = 7'h00;
    case (sel_q)
      3'b010:  cur_digit = tens_q;
      3'b100:  cur_digit = hundreds_q;
      default: cur_digit = ones_q;
    endcase
    seg_c = decode7(cur_digit);
    if (BLANK_LZ && sel_q == 3'b100 && hundreds_q == 4'd0) seg_c = 7'h00;
    if (BLANK_LZ && sel_q == 3'b010 && hundreds_q == 4'd0 && tens_q == 4'd0) seg_c = 7'h00;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hundreds  = hundreds_q;
  assign bus.tens      = tens_q;
  assign bus.ones      = ones_q;
  assign bus.digit_sel = sel_q;
  assign bus.seg       = seg_c;

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// Bench for alu_result_bcd_display: a blanking and a non-blanking instance share stimulus;
// digits and segments are predicted from decimal arithmetic on the last converted value.
module tb_alu_result_bcd_display;

  localparam int SD = 2;
  localparam int SCAN_PERIOD = 1 << SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_bcd_display_if bus_b ();
  alu_result_bcd_display_if bus_n ();

  assign bus_n.result_in = bus_b.result_in;
  assign bus_n.start     = bus_b.start;

  alu_result_bcd_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );
  alu_result_bcd_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n.slave)
  );

  typedef struct {
    logic [7:0] v;
    int         h;
    int         t;
    int         o;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int shown    = 0;

  logic [6:0] seg_lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Clock edges seen since reset released; scan position follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] model_seg(input int idx, input int v, input bit blank);
    int h, t, o, d;
    logic [6:0] s;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    d = (idx == 0) ? o : (idx == 1) ? t : h;
    s = seg_lut[d];
    if (blank && idx == 2 && h == 0) s = 7'h00;
    if (blank && idx == 1 && h == 0 && t == 0) s = 7'h00;
    return s;
  endfunction

  task automatic check_display(input string tag);
    int idx;
    idx = (cyc / SCAN_PERIOD) % 3;
    check({tag, " digit_sel"}, 32'(bus_b.digit_sel), 32'(1 << idx));
    check({tag, " seg_blank"}, 32'(bus_b.seg), 32'(model_seg(idx, shown, 1'b1)));
    check({tag, " seg_noblank"}, 32'(bus_n.seg), 32'(model_seg(idx, shown, 1'b0)));
  endtask

  task automatic check_digits(input string tag, input int h, input int t, input int o);
    check({tag, " hundreds"}, 32'(bus_b.hundreds), h);
    check({tag, " tens"}, 32'(bus_b.tens), t);
    check({tag, " ones"}, 32'(bus_b.ones), o);
  endtask

  // Full conversion with an idle start afterwards; result_in is scrambled after the accept edge.
  task automatic convert(input logic [7:0] v, input int h, input int t, input int o);
    bus_b.result_in = v;
    bus_b.start     = 1'b1;
    tick();
    bus_b.start     = 1'b0;
    bus_b.result_in = 8'($urandom);
    check("accept busy", 32'(bus_b.busy), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("shift busy", 32'(bus_b.busy), 1);
      check("shift done", 32'(bus_b.done), 0);
      if (i == 4) check_digits("held", shown / 100, (shown / 10) % 10, shown % 10);
    end
    tick();
    check("latch done", 32'(bus_b.done), 1);
    check("latch busy", 32'(bus_b.busy), 0);
    check_digits("latch", h, t, o);
    shown = int'(v);
    check_display("latch");
    tick();
    check("post done", 32'(bus_b.done), 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   vals [3];
    int   v;

    bus_b.start     = 1'b0;
    bus_b.result_in = 8'd0;

    vecs[0] = '{8'd255, 2, 5, 5};
    vecs[1] = '{8'd0,   0, 0, 0};
    vecs[2] = '{8'h47,  0, 7, 1};
    vecs[3] = '{8'd9,   0, 0, 9};
    vecs[4] = '{8'd100, 1, 0, 0};
    vecs[5] = '{8'd128, 1, 2, 8};

    // Reset state
    #12;
    check("rst busy", 32'(bus_b.busy), 0);
    check("rst done", 32'(bus_b.done), 0);
    check_digits("rst", 0, 0, 0);
    check("rst digit_sel", 32'(bus_b.digit_sel), 32'h1);
    check("rst seg", 32'(bus_b.seg), 32'h3F);
    tick();
    rst_n = 1'b1;

    // Table vectors, each followed by a full scan rotation
    foreach (vecs[i]) begin
      convert(vecs[i].v, vecs[i].h, vecs[i].t, vecs[i].o);
      for (int k = 0; k < 3 * SCAN_PERIOD; k++) begin
        check_display("scan");
        tick();
      end
    end

    // start held through the conversion: one done only, then re-accept in the done cycle
    bus_b.result_in = 8'd123;
    bus_b.start     = 1'b1;
    tick();
    bus_b.result_in = 8'd9;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("hold busy", 32'(bus_b.busy), 1);
      check("hold done", 32'(bus_b.done), 0);
    end
    tick();
    check("hold done pulse", 32'(bus_b.done), 1);
    check("hold busy low", 32'(bus_b.busy), 0);
    check_digits("hold", 1, 2, 3);
    shown = 123;
    tick();
    check("reaccept busy", 32'(bus_b.busy), 1);
    check("reaccept done", 32'(bus_b.done), 0);
    bus_b.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("reaccept no done", 32'(bus_b.done), 0);
    end
    tick();
    check("reaccept done pulse", 32'(bus_b.done), 1);
    check_digits("reaccept", 0, 0, 9);
    shown = 9;
    tick();

    // Reset mid-conversion
    bus_b.result_in = 8'd200;
    bus_b.start     = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus_b.busy), 0);
    check("abort done", 32'(bus_b.done), 0);
    check_digits("abort", 0, 0, 0);
    shown = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort no done", 32'(bus_b.done), 0);
      check_display("abort scan");
    end
    convert(8'd200, 2, 0, 0);

    // Back-to-back with start held high
    vals = '{10, 99, 100};
    bus_b.result_in = 8'(vals[0]);
    bus_b.start     = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i <= 8; i++) begin
        tick();
        check("b2b busy", 32'(bus_b.busy), 1);
        check("b2b done", 32'(bus_b.done), 0);
      end
      tick();
      check("b2b done pulse", 32'(bus_b.done), 1);
      check_digits("b2b", vals[k] / 100, (vals[k] / 10) % 10, vals[k] % 10);
      shown = vals[k];
      check_display("b2b");
      if (k < 2) bus_b.result_in = 8'(vals[k + 1]);
      else       bus_b.start = 1'b0;
      tick();
      check("b2b next busy", 32'(bus_b.busy), (k < 2) ? 1 : 0);
    end

    // Randomized values against decimal arithmetic
    for (int r = 0; r < 20; r++) begin
      v = int'($urandom_range(0, 255));
      convert(8'(v), v / 100, (v / 10) % 10, v % 10);
      for (int k = 0; k < 6; k++) begin
        check_display("rand scan");
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
